// File: rtl/mem_pkg.sv
// Shared types for the block RAM slice: clear FSM states
// and read-during-write mode constants.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once,
// then raises ready for the rest of time.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1,
  parameter int AW             = addr_bits(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          // stop on the last word so cnt never wraps
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: ready_q <= 1'b1;
      endcase
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_block_ram.sv
// Byte-enabled simple dual-port RAM with a pipelined read
// path, selectable read-during-write and zero-fill on reset.
module mem_block_ram
  import mem_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 1024,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        wraddress,
  input  logic [15:0]        rdaddress,
  input  logic               wren,
  input  logic [WIDTH/8-1:0] byteena,
  input  logic [WIDTH-1:0]   data,
  input  logic               rden,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic               ready
);

  localparam int BW = WIDTH / 8;
  localparam int AW = addr_bits(DEPTH);
  localparam int L  = RD_LATENCY;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_ok, rd_ok;
  logic             wr_en, rd_en, rdw_hit;
  logic [AW-1:0]    wa, ra;
  logic [WIDTH-1:0] merged, rd_word;

  logic [WIDTH-1:0] rd0_q;
  logic [WIDTH-1:0] pipe_q [L];
  logic [L:0]       vld_q;

  mem_clear_seq #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_clr (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok   = 32'(wraddress) < DEPTH;
  assign rd_ok   = 32'(rdaddress) < DEPTH;
  assign wa      = wraddress[AW-1:0];
  assign ra      = rdaddress[AW-1:0];
  assign wr_en   = ready & wren & wr_ok & ~reset;
  assign rd_en   = ready & rden & ~reset;
  assign rdw_hit = wr_en & (wraddress == rdaddress);

  always_comb begin
    merged = mem[ra];
    for (int b = 0; b < BW; b++) begin
      if (byteena[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
  end

  always_comb begin
    rd_word = mem[ra];
    if (!rd_ok) rd_word = '0;
    else if (RDW_MODE == RDW_NEW && rdw_hit) rd_word = merged;
  end

  // storage is never reset; the clear sequencer zero-fills it
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BW; b++) begin
        if (byteena[b]) mem[wa][8*b +: 8] <= data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rd_en) rd0_q <= rd_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < L; s++) pipe_q[s] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      if (vld_q[0]) pipe_q[0] <= rd0_q;
      for (int s = 1; s < L; s++) begin
        if (vld_q[s]) pipe_q[s] <= pipe_q[s-1];
      end
      for (int s = 0; s < L; s++) vld_q[s+1] <= vld_q[s];
    end
  end

  assign q       = pipe_q[L-1];
  assign q_valid = vld_q[L];

endmodule

// File: tb/tb_mem_block_ram.sv
// Two RAM configurations share one stimulus stream; each
// has its own expected-read queue drained by a monitor.
module tb_mem_block_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] wraddress, rdaddress, data;
  logic        wren, rden;
  logic [1:0]  byteena;
  logic [15:0] q_a, q_b;
  logic        qv_a, qv_b, rdy_a, rdy_b;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;
  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   na, nb;

  mem_block_ram #(
    .WIDTH(16), .DEPTH(16), .RD_LATENCY(1),
    .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset(reset),
    .wraddress(wraddress), .rdaddress(rdaddress),
    .wren(wren), .byteena(byteena), .data(data),
    .rden(rden), .q(q_a), .q_valid(qv_a), .ready(rdy_a)
  );

  mem_block_ram #(
    .WIDTH(16), .DEPTH(16), .RD_LATENCY(2),
    .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clock(clock), .reset(reset),
    .wraddress(wraddress), .rdaddress(rdaddress),
    .wren(wren), .byteena(byteena), .data(data),
    .rden(rden), .q(q_b), .q_valid(qv_b), .ready(rdy_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    if (qv_a === 1'b1) begin
      n_cmp++;
      if (sb_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_unexpected q=%h edge=%0d", q_a, edge_cnt);
      end else begin
        ea = sb_a.pop_front();
        if (q_a !== ea.d || edge_cnt != ea.due) begin
          n_bad++;
          $display("FAIL a_read got q=%h edge=%0d need q=%h edge=%0d",
                   q_a, edge_cnt, ea.d, ea.due);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (qv_b === 1'b1) begin
      n_cmp++;
      if (sb_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_unexpected q=%h edge=%0d", q_b, edge_cnt);
      end else begin
        eb = sb_b.pop_front();
        if (q_b !== eb.d || edge_cnt != eb.due) begin
          n_bad++;
          $display("FAIL b_read got q=%h edge=%0d need q=%h edge=%0d",
                   q_b, edge_cnt, eb.d, eb.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h need %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] xa,
                    input logic [15:0] xb);
    rden = 1'b1; rdaddress = a;
    sb_a.push_back('{xa, edge_cnt + 2});
    sb_b.push_back('{xb, edge_cnt + 3});
    tick();
    rden = 1'b0;
  endtask

  task automatic rw(input logic [15:0] a, input logic [15:0] d,
                    input logic [1:0] be, input logic [15:0] xa,
                    input logic [15:0] xb);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    rden = 1'b1; rdaddress = a;
    sb_a.push_back('{xa, edge_cnt + 2});
    sb_b.push_back('{xb, edge_cnt + 3});
    tick();
    wren = 1'b0; rden = 1'b0;
  endtask

  // counts edges after reset release until ready; optionally
  // pokes a read and a write that must be ignored while clearing
  task automatic measure(input bit poke, output int ra_n,
                         output int rb_n);
    ra_n = -1; rb_n = -1;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 1) begin
        rden = 1'b1; rdaddress = 16'd7;
        wren = 1'b1; wraddress = 16'd2;
        data = 16'hDEAD; byteena = 2'b11;
      end
      if (k == 11) begin
        rden = 1'b0; wren = 1'b0;
      end
      tick();
      if (ra_n < 0 && rdy_a === 1'b1) ra_n = k;
      if (rb_n < 0 && rdy_b === 1'b1) rb_n = k;
    end
    rden = 1'b0; wren = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; rden = 1'b0;
    wraddress = '0; rdaddress = '0; data = '0; byteena = '0;
    tick();
    chk("rst_q_a", q_a, 0);
    chk("rst_qv_a", qv_a, 0);
    chk("rst_rdy_a", rdy_a, 0);
    chk("rst_q_b", q_b, 0);
    chk("rst_rdy_b", rdy_b, 0);
    reset = 1'b0;
    measure(1'b1, na, nb);
    chk("clr_len_a", na, 16);
    chk("clr_len_b", nb, 16);

    for (int i = 0; i < 16; i++) rd(16'(i), 16'h0, 16'h0);

    wr(16'd5, 16'hABCD, 2'b11);
    wr(16'd5, 16'h1234, 2'b01);
    rd(16'd5, 16'hAB34, 16'hAB34);

    wr(16'd3, 16'h1111, 2'b11);
    rw(16'd3, 16'h2222, 2'b11, 16'h1111, 16'h2222);
    rd(16'd3, 16'h2222, 16'h2222);
    rw(16'd3, 16'h3344, 2'b01, 16'h2222, 16'h2244);
    rd(16'd3, 16'h2244, 16'h2244);

    wr(16'd0, 16'hA0A0, 2'b11);
    wr(16'd1, 16'hB1B1, 2'b11);
    wr(16'd2, 16'hC2C2, 2'b11);
    wr(16'd3, 16'hD3D3, 2'b11);
    rd(16'd0, 16'hA0A0, 16'hA0A0);
    rd(16'd1, 16'hB1B1, 16'hB1B1);
    rd(16'd2, 16'hC2C2, 16'hC2C2);
    rd(16'd3, 16'hD3D3, 16'hD3D3);

    wr(16'd20, 16'hFFFF, 2'b11);
    rd(16'd20, 16'h0, 16'h0);
    rd(16'd4, 16'h0, 16'h0);
    rd(16'd5, 16'hAB34, 16'hAB34);

    repeat (5) tick();
    chk("hold_q_a", q_a, 16'hAB34);
    chk("hold_q_b", q_b, 16'hAB34);
    chk("hold_qv_a", qv_a, 0);
    chk("hold_qv_b", qv_b, 0);

    // read in flight when reset hits: must vanish
    rden = 1'b1; rdaddress = 16'd1;
    tick();
    rden = 1'b0; reset = 1'b1;
    tick();
    chk("flush_rdy_a", rdy_a, 0);
    chk("flush_q_a", q_a, 0);
    reset = 1'b0;
    measure(1'b0, na, nb);
    chk("flush_len_a", na, 16);
    chk("flush_len_b", nb, 16);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    rden = 1'b1; rdaddress = 16'd0;
    tick();
    rden = 1'b0; reset = 1'b1;
    tick();
    chk("mid_rdy_b", rdy_b, 0);
    reset = 1'b0;
    measure(1'b0, na, nb);
    chk("mid_len_a", na, 16);
    chk("mid_len_b", nb, 16);
    rd(16'd5, 16'h0, 16'h0);
    rd(16'd1, 16'h0, 16'h0);

    repeat (6) tick();
    chk("sb_a_empty", sb_a.size(), 0);
    chk("sb_b_empty", sb_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
